serial_receiver: RTL

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_receiver_pkg.sv | 12 +
 rtl/serial_receiver_sat_counter.sv | 16 +
 rtl/serial_receiver.sv | 76 +++++++
 3 files changed

// File: rtl/serial_receiver_pkg.sv
// Shared frame constants and FSM encoding for the serial link (receiver and transmitter).
package serial_receiver_pkg;
    localparam int   DEF_DATA_W = 8;
    localparam int   DEF_ERR_W  = 4;
    localparam logic START_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } rx_state_t;
endpackage

// File: rtl/serial_receiver_sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)
            count <= '0;
        else if (en && (count != '1))
            count <= count + W'(1);
    end
endmodule

// File: rtl/serial_receiver.sv
// Frame receiver: start bit, DATA_W payload bits MSB first, even-XOR parity bit.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              SDin,
    output logic [DATA_W-1:0] PDout,
    output logic              Valid,
    output logic              ParityErr,
    output logic              Busy,
    output logic [ERR_W-1:0]  ErrCount
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              mismatch;
    logic              err_inc;

    // Only feeds register inputs, so outputs stay free of SDin paths.
    assign mismatch = SDin ^ (^shreg);
    assign err_inc  = (state == PARITY) && mismatch;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            PDout     <= '0;
            Valid     <= 1'b0;
            ParityErr <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (SDin == START_BIT) begin
                        state <= DATA;
                        cnt   <= CNT_W'(DATA_W - 1);
                        Busy  <= 1'b1;
                    end
                end
                DATA: begin
                    shreg <= DATA_W'({shreg, SDin});
                    if (cnt == '0)
                        state <= PARITY;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                PARITY: begin
                    PDout     <= shreg;
                    ParityErr <= mismatch;
                    Valid     <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .Clk    (Clk),
        .nReset (nReset),
        .en     (err_inc),
        .count  (ErrCount)
    );
endmodule
